// File: rtl/countdown_display.sv
// ============================================================================
// Module   : countdown_display
// Purpose  : Two-digit 7-segment countdown display (00..59) with zero-blink.
// Options  : define LEADING_ZERO_BLANK_EN to blank a leading zero tens digit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module countdown_display #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int SCAN_HZ  = 1_000,
  parameter int BLINK_HZ = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] seconds_in,
  input  logic       load,
  output logic [6:0] seg_n,
  output logic [1:0] an_n,
  output logic       zero_flag
);

  localparam int SCAN_DIV  = CLK_HZ / (2 * SCAN_HZ);
  localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
  localparam int SCAN_W    = $clog2(SCAN_DIV + 1);
  localparam int BLINK_W   = $clog2(BLINK_DIV + 1);
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  typedef enum logic {
    ONES = 1'b0,
    TENS = 1'b1
  } digit_t;

  logic [5:0]         value;
  logic [3:0]         tens;
  logic [3:0]         ones;
  logic [SCAN_W-1:0]  scan_cnt;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;
  digit_t             digit_sel;
  logic [6:0]         seg_next;
  logic [1:0]         an_next;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h40;
      4'd1:    decode = 7'h79;
      4'd2:    decode = 7'h24;
      4'd3:    decode = 7'h30;
      4'd4:    decode = 7'h19;
      4'd5:    decode = 7'h12;
      4'd6:    decode = 7'h02;
      4'd7:    decode = 7'h78;
      4'd8:    decode = 7'h00;
      4'd9:    decode = 7'h10;
      default: decode = 7'h7F;
    endcase
  endfunction

  // Enable and pattern come from the same select so they always register as a pair.
  always_comb begin
    seg_next = decode(ones);
    an_next  = 2'b10;
    if (digit_sel == TENS) begin
      seg_next = decode(tens);
      an_next  = 2'b01;
`ifdef LEADING_ZERO_BLANK_EN
      if (tens == 4'd0) an_next = 2'b11;
`endif
    end
    if (zero_flag && blink_phase) an_next = 2'b11;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value       <= 6'd59;
      tens        <= 4'd5;
      ones        <= 4'd9;
      zero_flag   <= 1'b0;
      scan_cnt    <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      digit_sel   <= ONES;
      an_n        <= 2'b11;
      seg_n       <= 7'h7F;
    end else begin
      if (load) value <= (seconds_in > 6'd59) ? 6'd59 : seconds_in;

      tens      <= 4'(value / 6'd10);
      ones      <= 4'(value % 6'd10);
      zero_flag <= (value == 6'd0);

      if (scan_cnt == SCAN_LAST) begin
        scan_cnt  <= '0;
        digit_sel <= (digit_sel == ONES) ? TENS : ONES;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end

      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end

      seg_n <= seg_next;
      an_n  <= an_next;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_countdown_display.sv
// ============================================================================
// Module   : tb_countdown_display
// Purpose  : Directed self-checking bench for countdown_display (SCAN_DIV=5,
//            BLINK_DIV=50).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_countdown_display;

  logic       clk;
  logic       reset;
  logic [5:0] seconds_in;
  logic       load;
  logic [6:0] seg_n;
  logic [1:0] an_n;
  logic       zero_flag;

  int checks;
  int errors;
  int k;

  countdown_display #(
    .CLK_HZ  (1000),
    .SCAN_HZ (100),
    .BLINK_HZ(10)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .seconds_in(seconds_in),
    .load      (load),
    .seg_n     (seg_n),
    .an_n      (an_n),
    .zero_flag (zero_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, k);
    end
  endtask

  task automatic rst_release();
    load       = 1'b0;
    seconds_in = 6'd0;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    k = 0;
  endtask

  // Inputs change at the falling edge; outputs are sampled at the next falling edge.
  task automatic step(input logic ld, input logic [5:0] v);
    load       = ld;
    seconds_in = v;
    @(posedge clk);
    k++;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Run up to cycle n with no further loads.
  task automatic run_to(input int n);
    while (k < n) step(1'b0, 6'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    k      = 0;
    reset  = 1'b0;

    // Reset values and the 59 scan sequence
    rst_release();
    check("rst_an", {30'd0, an_n}, 32'h3);
    check("rst_seg", {25'd0, seg_n}, 32'h7F);
    check("rst_zf", {31'd0, zero_flag}, 32'h0);
    run_to(1);
    check("scan_k1_an", {30'd0, an_n}, 32'h2);
    check("scan_k1_seg", {25'd0, seg_n}, 32'h10);
    run_to(5);
    check("scan_k5_an", {30'd0, an_n}, 32'h2);
    run_to(6);
    check("scan_k6_an", {30'd0, an_n}, 32'h1);
    check("scan_k6_seg", {25'd0, seg_n}, 32'h12);
    run_to(10);
    check("scan_k10_an", {30'd0, an_n}, 32'h1);
    run_to(11);
    check("scan_k11_an", {30'd0, an_n}, 32'h2);

    // Load 37
    rst_release();
    step(1'b1, 6'd37);
    run_to(3);
    check("l37_ones_seg", {25'd0, seg_n}, 32'h78);
    check("l37_ones_an", {30'd0, an_n}, 32'h2);
    check("l37_zf", {31'd0, zero_flag}, 32'h0);
    run_to(7);
    check("l37_tens_seg", {25'd0, seg_n}, 32'h30);
    check("l37_tens_an", {30'd0, an_n}, 32'h1);

    // Saturation
    rst_release();
    step(1'b1, 6'd63);
    run_to(3);
    check("l63_ones_seg", {25'd0, seg_n}, 32'h10);
    run_to(7);
    check("l63_tens_seg", {25'd0, seg_n}, 32'h12);

    // Load 7: leading zero handling
    rst_release();
    step(1'b1, 6'd7);
    run_to(3);
    check("l7_ones_seg", {25'd0, seg_n}, 32'h78);
    run_to(7);
`ifdef LEADING_ZERO_BLANK_EN
    check("l7_tens_an", {30'd0, an_n}, 32'h3);
`else
    check("l7_tens_an", {30'd0, an_n}, 32'h1);
    check("l7_tens_seg", {25'd0, seg_n}, 32'h40);
`endif

    // Back-to-back loads, last wins, then held
    rst_release();
    step(1'b1, 6'd12);
    step(1'b1, 6'd48);
    run_to(4);
    check("b2b_ones_seg", {25'd0, seg_n}, 32'h00);
    run_to(7);
    check("b2b_tens_seg", {25'd0, seg_n}, 32'h19);
    run_to(25);
    check("hold_ones_seg", {25'd0, seg_n}, 32'h00);
    run_to(28);
    check("hold_tens_seg", {25'd0, seg_n}, 32'h19);

    // Load coinciding with refresh terminal count (edge 5)
    rst_release();
    run_to(4);
    step(1'b1, 6'd21);
    run_to(7);
    check("tc_tens_seg", {25'd0, seg_n}, 32'h24);
    check("tc_tens_an", {30'd0, an_n}, 32'h1);
    run_to(11);
    check("tc_ones_seg", {25'd0, seg_n}, 32'h79);

    // Zero blink: blank during outputs 51..100, scanning 101..150
    rst_release();
    step(1'b1, 6'd0);
    check("z_zf_k1", {31'd0, zero_flag}, 32'h0);
    run_to(2);
    check("z_zf_k2", {31'd0, zero_flag}, 32'h1);
    run_to(3);
    check("z_ones_seg", {25'd0, seg_n}, 32'h40);
    check("z_ones_an", {30'd0, an_n}, 32'h2);
    run_to(7);
    check("z_tens_seg", {25'd0, seg_n}, 32'h40);
    run_to(50);
    check("z_k50_an", {30'd0, an_n}, 32'h1);
    run_to(51);
    check("z_k51_an", {30'd0, an_n}, 32'h3);
    run_to(100);
    check("z_k100_an", {30'd0, an_n}, 32'h3);
    run_to(101);
    check("z_k101_an", {30'd0, an_n}, 32'h2);
    check("z_k101_seg", {25'd0, seg_n}, 32'h40);
    run_to(155);
    check("z_k155_an", {30'd0, an_n}, 32'h3);

    // Asynchronous reset mid-blink
    #2 reset = 1'b1;
    #1;
    check("arst_an", {30'd0, an_n}, 32'h3);
    check("arst_seg", {25'd0, seg_n}, 32'h7F);
    check("arst_zf", {31'd0, zero_flag}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    k = 0;
    run_to(1);
    check("arst_k1_seg", {25'd0, seg_n}, 32'h10);
    run_to(6);
    check("arst_k6_seg", {25'd0, seg_n}, 32'h12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
